// File: rtl/shift_sequencer.sv
// Multi-cycle 8-bit shifter: one single-bit shift/rotate per clock, start/busy/done handshake.
// Optional rotate mode (ROT port) is built only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [2:0] AMT,
  input  logic       LR,
  input  logic       LA,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic       ROT,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] Y,
  output logic       C,
  output logic       Z
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] y_q, y_d;
  logic       c_q, c_d;
  logic [2:0] cnt_q, cnt_d;
  logic       lr_q, lr_d;
  logic       la_q, la_d;
  logic       rot_q, rot_d;
  logic       rot_in;
  logic [7:0] step_y;
  logic       step_c;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign rot_in = ROT;
`else
  assign rot_in = 1'b0;
`endif

  // Single-bit stage; the bit shifted out always becomes the carry.
  always_comb begin
    step_y = y_q;
    step_c = c_q;
    if (!lr_q) begin
      step_y = {y_q[6:0], (rot_q ? y_q[7] : 1'b0)};
      step_c = y_q[7];
    end else begin
      if (rot_q) begin
        step_y = {y_q[0], y_q[7:1]};
      end else begin
        step_y = {(la_q ? y_q[7] : 1'b0), y_q[7:1]};
      end
      step_c = y_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    la_d    = la_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          y_d     = A;
          c_d     = 1'b0;
          cnt_d   = AMT;
          lr_d    = LR;
          la_d    = LA;
          rot_d   = rot_in;
          state_d = (AMT == 3'd0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        y_d   = step_y;
        c_d   = step_c;
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= 8'h00;
      c_q     <= 1'b0;
      cnt_q   <= 3'd0;
      lr_q    <= 1'b0;
      la_q    <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      la_q    <= la_d;
      rot_q   <= rot_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign Y    = y_q;
  assign C    = c_q;
  assign Z    = (y_q == 8'h00);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer; rotate cases run only with SHIFT_SEQ_ROTATE_EN.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic       lr;
  logic       la;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic       rot;
`endif
  logic       busy;
  logic       done;
  logic [7:0] y;
  logic       c;
  logic       z;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (a),
    .AMT   (amt),
    .LR    (lr),
    .LA    (la),
`ifdef SHIFT_SEQ_ROTATE_EN
    .ROT   (rot),
`endif
    .busy  (busy),
    .done  (done),
    .Y     (y),
    .C     (c),
    .Z     (z)
  );

  typedef struct {
    logic [7:0] y;
    logic       c;
    logic [2:0] amt;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: apply the documented single-bit rule amt times.
  function automatic exp_t model(input logic [7:0] ai, input logic [2:0] n,
                                 input logic dir_r, input logic arith, input logic rt);
    exp_t e;
    logic [7:0] v;
    logic       cf;
    v  = ai;
    cf = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      if (!dir_r) begin
        cf = v[7];
        v  = rt ? {v[6:0], v[7]} : {v[6:0], 1'b0};
      end else begin
        cf = v[0];
        v  = rt ? {v[0], v[7:1]} : (arith ? {v[7], v[7:1]} : {1'b0, v[7:1]});
      end
    end
    e.y = v;
    e.c = cf;
    e.amt = n;
    e.done_cyc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("y", y, e.y);
          check("c", c, e.c);
          check("z", z, (e.y == 8'h00));
          check("busy_cycles", busy_cnt, e.amt);
          check("latency", cyc, e.done_cyc);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called just after an edge; start is left high for the caller to drop.
  task automatic issue(input logic [7:0] ai, input logic [2:0] n,
                       input logic dir_r, input logic arith, input logic rt);
    exp_t e;
    a = ai; amt = n; lr = dir_r; la = arith;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot = rt;
`endif
    start = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
    e = model(ai, n, dir_r, arith, rt);
`else
    e = model(ai, n, dir_r, arith, 1'b0);
`endif
    e.done_cyc = cyc + 1 + int'(n);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1;
        break;
      end
      step();
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [7:0] ai, input logic [2:0] n,
                        input logic dir_r, input logic arith, input logic rt);
    issue(ai, n, dir_r, arith, rt);
    step();
    start = 1'b0;
    wait_done();
    step();
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; a = 8'h00; amt = 3'd0; lr = 1'b0; la = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot = 1'b0;
`endif
    step(); step();
    check("rst_y", y, 8'h00);
    check("rst_c", c, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z", z, 1);
    reset = 1'b0;
    step();

    issue(8'h81, 3'd1, 1'b0, 1'b0, 1'b0);
    step(); start = 1'b0;
    wait_done();
    check("tp1_y", y, 8'h02);
    check("tp1_c", c, 1);
    step();

    run_op(8'h94, 3'd3, 1'b1, 1'b1, 1'b0);
    check("tp2_y", y, 8'hF2);
    check("tp2_c", c, 1);

    // Second start mid-SHIFT must be ignored.
    issue(8'h94, 3'd7, 1'b1, 1'b0, 1'b0);
    step(); start = 1'b0;
    step(); step();
    a = 8'hFF; amt = 3'd2; start = 1'b1;
    step(); start = 1'b0; a = 8'h00;
    wait_done();
    check("tp3_y", y, 8'h01);
    check("tp3_c", c, 0);
    step();
    check("tp3_no_second_done", done, 0);

    // Back-to-back: AMT=0 op, second op accepted in the DONE cycle.
    issue(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("b2b_first_done", done, 1);
    check("b2b_first_y", y, 8'h5A);
    issue(8'h01, 3'd1, 1'b1, 1'b0, 1'b0);
    step(); start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done();
    check("b2b_y", y, 8'h00);
    check("b2b_z", z, 1);
    step();

    // Reset mid-SHIFT aborts with no done pulse.
    issue(8'hFF, 3'd5, 1'b0, 1'b0, 1'b0);
    step(); start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check("abort_y", y, 8'h00);
    check("abort_c", c, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_z", z, 1);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      step();
    end
    check("abort_no_done", dones, 0);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_op(8'h81, 3'd1, 1'b0, 1'b0, 1'b1);
    check("rot1_y", y, 8'h03);
    check("rot1_c", c, 1);
    run_op(8'h81, 3'd2, 1'b1, 1'b1, 1'b1);
    check("rot2_y", y, 8'h60);
    check("rot2_c", c, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      run_op(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    step(); step();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit that sits directly upstream of the single-bit combinational shifter stage in the datapath. It accepts an 8-bit operand, a shift amount of 0–7 and a shift mode, then applies one single-bit shift per clock until the amount is consumed. The shift semantics match the single-bit stage, including the carry-out. It returns the result, the final carry and a zero flag to the ALU/flags logic with a start/busy/done handshake.

## Interface
- No parameters; data width fixed at 8, amount width fixed at 3.
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  8  operand, captured on accepted start
- AMT  input  3  shift count 0–7, captured on accepted start
- LR  input  1  direction: 0 = left, 1 = right; captured on accepted start
- LA  input  1  right-shift type: 1 = arithmetic, 0 = logical; ignored for left; captured on accepted start
- ROT  input  1  rotate select; present only with SHIFT_SEQ_ROTATE_EN; captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; result valid
- Y  output  8  result register
- C  output  1  last bit shifted out
- Z  output  1  combinational (Y == 8'h00)

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → load Y←A, count←AMT and the mode bits; C←0.
  - If AMT==0 → DONE, otherwise → SHIFT.
- SHIFT: each cycle applies one single-bit shift to Y and updates C, then count←count−1.
  - When count reaches 0 after the shift → DONE.
- Single-bit shift rules:
  - Left: Y←{Y[6:0],0}, C←Y[7].
  - Right arithmetic: Y←{Y[7],Y[7:1]}, C←Y[0].
  - Right logical: Y←{0,Y[7:1]}, C←Y[0].
- DONE: done=1 for exactly this cycle.
  - start=1 → accept a new operation, same as IDLE (back-to-back).
  - Otherwise → IDLE.
- Y and C hold their values in IDLE and DONE until the next accepted start.
- start during SHIFT is ignored: no queueing, no error.
- Input changes after capture have no effect.
- AMT==0: Y=A, C=0.

## Timing
- Reset values: state IDLE, Y=8'h00, C=0, busy=0, done=0, Z=1.
- Capture edge E0: the edge where start is accepted.
- done is high in the cycle following edge E(AMT), i.e. AMT+1 edges after start is presented.
  - Latency is 1 cycle for AMT=0 and 8 cycles for AMT=7.
- busy is high for exactly AMT cycles, starting the cycle after E0; it is never high when AMT=0.
- done and busy are never high together.
- Back-to-back: start held high in the DONE cycle gives done, then busy (or done again for AMT=0), on the next cycle with no idle gap.
- Reset asserted mid-operation, including during SHIFT or DONE:
  - Next edge forces the reset values.
  - No done pulse is produced for the aborted operation.
  - reset has priority over start.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined:
  - ROT port exists.
  - When the captured ROT=1, each step rotates instead of shifting and LA is ignored.
    - Left: Y←{Y[6:0],Y[7]}, C←Y[7].
    - Right: Y←{Y[0],Y[7:1]}, C←Y[0].
- SHIFT_SEQ_ROTATE_EN not defined:
  - ROT port is absent.
  - Behaviour is identical to ROT=0.

## Test plan
- Reset, then A=8'h81, AMT=1, LR=0, start → done 1 cycle after capture edge; Y=8'h02, C=1, Z=0, busy high for 1 cycle.
- A=8'h94, AMT=3, LR=1, LA=1 → busy 3 cycles then done; Y=8'hF2, C=1.
- A=8'h94, AMT=7, LR=1, LA=0; pulse start again mid-SHIFT with A=8'hFF → second start ignored; Y=8'h01, C=0, Z=0, busy 7 cycles.
- A=8'h5A, AMT=0, start held high; next op A=8'h01, AMT=1, LR=1, LA=0 →
  - done after capture edge with Y=8'h5A, C=0, busy never high.
  - Second op accepted in the DONE cycle; Y=8'h00, C=1, Z=1 after its done.
- A=8'hFF, AMT=5, LR=0; assert reset for one cycle after 2 shifts → Y=8'h00, C=0, busy=0, done=0; no done pulse follows.
- With SHIFT_SEQ_ROTATE_EN: A=8'h81, AMT=1, LR=0, ROT=1 → Y=8'h03, C=1. Then A=8'h81, AMT=2, LR=1, ROT=1 → Y=8'h60, C=0.
